// File: rtl/dtc_pingpong_ctrl.sv
// Ping-pong controller: streams BRAM words into two FIFOs and reads the idle bank out as a serial word stream.
// Define DTC_PP_ERR_EN to get sticky ovf/udf flags; without it they are tied low (strobes are still suppressed).
module dtc_pingpong_ctrl #(
    parameter int DW      = 4,
    parameter int AW      = 11,
    parameter int DEPTH   = 1536,
    parameter int PKT_LEN = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    output logic [AW-1:0] bram_addr,
    input  logic [DW-1:0] bram_dout,
    output logic          wr_en_0,
    output logic          wr_en_1,
    output logic [DW-1:0] din_0,
    output logic [DW-1:0] din_1,
    output logic          rd_en_0,
    output logic          rd_en_1,
    input  logic [DW-1:0] dout_0,
    input  logic [DW-1:0] dout_1,
    input  logic          full_0,
    input  logic          full_1,
    input  logic          empty_0,
    input  logic          empty_1,
    output logic [DW-1:0] sr_out,
    output logic          sr_valid,
    output logic          bank,
    output logic          pkt_start,
    output logic          ovf,
    output logic          udf
);

    localparam int            CW        = (PKT_LEN > 2) ? $clog2(PKT_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(PKT_LEN - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t        state;
    logic          draining;
    logic          stop_req;
    logic          bank_r;
    logic [AW-1:0] addr;
    logic [CW-1:0] pkt_cnt;
    logic          wr_pend;
    logic          wr_bank;
    logic          rd_valid;
    logic          rd_bank;

    logic          issuing;
    logic          reading;
    logic          rd_sel;
    logic          rd_empty;
    logic          cnt_last;

    // Drain reads the last filled bank out without issuing new BRAM addresses.
    assign issuing  = (state == PRIME) || ((state == RUN) && !draining);
    assign reading  = (state == RUN);
    assign rd_sel   = ~bank_r;
    assign rd_empty = rd_sel ? empty_1 : empty_0;
    assign cnt_last = (pkt_cnt == CNT_LAST);

    assign bram_addr = addr;
    assign bank      = bank_r;
    assign pkt_start = reading && (pkt_cnt == '0);

    // BRAM data arrives one cycle after the address, so the write side follows the issue pipeline bit.
    assign wr_en_0 = wr_pend && !wr_bank && !full_0;
    assign wr_en_1 = wr_pend &&  wr_bank && !full_1;
    assign din_0   = (wr_pend && !wr_bank) ? bram_dout : '0;
    assign din_1   = (wr_pend &&  wr_bank) ? bram_dout : '0;

    assign rd_en_0 = reading && !rd_sel && !empty_0;
    assign rd_en_1 = reading &&  rd_sel && !empty_1;

    // FIFO read data is valid the cycle after rd_en; the qualifier and source bank are registered.
    assign sr_valid = rd_valid;
    assign sr_out   = rd_valid ? (rd_bank ? dout_1 : dout_0) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            draining <= 1'b0;
            stop_req <= 1'b0;
            bank_r   <= 1'b0;
            addr     <= '0;
            pkt_cnt  <= '0;
            wr_pend  <= 1'b0;
            wr_bank  <= 1'b0;
            rd_valid <= 1'b0;
            rd_bank  <= 1'b0;
        end else begin
            wr_pend  <= issuing;
            wr_bank  <= bank_r;
            rd_valid <= reading && !rd_empty;
            rd_bank  <= rd_sel;

            if (issuing) begin
                addr <= (addr == ADDR_LAST) ? '0 : addr + AW'(1);
            end

            case (state)
                IDLE: begin
                    pkt_cnt  <= '0;
                    draining <= 1'b0;
                    stop_req <= 1'b0;
                    if (enable) begin
                        state  <= PRIME;
                        bank_r <= 1'b0;
                    end
                end
                PRIME, RUN: begin
                    pkt_cnt <= pkt_cnt + CW'(1);
                    if (!draining && !enable) begin
                        stop_req <= 1'b1;
                    end
                    if (cnt_last) begin
                        if (draining) begin
                            state    <= IDLE;
                            draining <= 1'b0;
                            stop_req <= 1'b0;
                        end else begin
                            state    <= RUN;
                            bank_r   <= ~bank_r;
                            draining <= stop_req || !enable;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DTC_PP_ERR_EN
    logic ovf_r;
    logic udf_r;

    // Sticky until reset: a dropped write or a skipped read slot is never forgotten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (wr_pend && (wr_bank ? full_1 : full_0)) begin
                ovf_r <= 1'b1;
            end
            if (reading && rd_empty) begin
                udf_r <= 1'b1;
            end
        end
    end

    assign ovf = ovf_r;
    assign udf = udf_r;
`else
    assign ovf = 1'b0;
    assign udf = 1'b0;
`endif

endmodule

// File: tb/tb_dtc_pingpong_ctrl.sv
// Self-checking bench for dtc_pingpong_ctrl: BRAM and FIFO models plus a cycle-indexed stream reference.
module tb_dtc_pingpong_ctrl;

    localparam int DW      = 4;
    localparam int AW      = 11;
    localparam int DEPTH   = 1536;
    localparam int PKT_LEN = 64;
`ifdef DTC_PP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout = '0;
    logic          wr_en_0, wr_en_1, rd_en_0, rd_en_1;
    logic [DW-1:0] din_0, din_1;
    logic [DW-1:0] dout_0 = '0;
    logic [DW-1:0] dout_1 = '0;
    logic          full_0 = 1'b0, full_1 = 1'b0, empty_0 = 1'b0, empty_1 = 1'b0;
    logic [DW-1:0] sr_out;
    logic          sr_valid, bank, pkt_start, ovf, udf;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] q0 [$];
    logic [DW-1:0] q1 [$];
    int push0 = 0, push1 = 0, pop0 = 0, pop1 = 0;

    dtc_pingpong_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .PKT_LEN(PKT_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .bram_addr(bram_addr), .bram_dout(bram_dout),
        .wr_en_0(wr_en_0), .wr_en_1(wr_en_1), .din_0(din_0), .din_1(din_1),
        .rd_en_0(rd_en_0), .rd_en_1(rd_en_1), .dout_0(dout_0), .dout_1(dout_1),
        .full_0(full_0), .full_1(full_1), .empty_0(empty_0), .empty_1(empty_1),
        .sr_out(sr_out), .sr_valid(sr_valid), .bank(bank), .pkt_start(pkt_start),
        .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    // Synchronous-read BRAM model.
    always @(posedge clk) begin
        bram_dout <= mem[bram_addr];
    end

    // FIFO models: data appears on dout the cycle after rd_en.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            dout_0 <= '0;
            dout_1 <= '0;
            push0 <= 0; push1 <= 0; pop0 <= 0; pop1 <= 0;
        end else begin
            if (wr_en_0) begin q0.push_back(din_0); push0 <= push0 + 1; end
            if (wr_en_1) begin q1.push_back(din_1); push1 <= push1 + 1; end
            if (rd_en_0) begin
                pop0 <= pop0 + 1;
                if (q0.size() > 0) dout_0 <= q0.pop_front(); else dout_0 <= '0;
            end
            if (rd_en_1) begin
                pop1 <= pop1 + 1;
                if (q1.size() > 0) dout_1 <= q1.pop_front(); else dout_1 <= '0;
            end
        end
    end

    task automatic do_reset(input bit ramp);
        rst_n = 1'b0;
        enable = 1'b0;
        full_0 = 1'b0; full_1 = 1'b0; empty_0 = 1'b0; empty_1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = ramp ? DW'(i) : DW'($urandom);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference: cycle t=1 is the first PRIME cycle. Issue t writes at t+1; packet reads start at PKT_LEN+1;
    // the k-th serial word is BRAM word k. A drop at cycle drop_t ends issuing at the end of that packet.
    task automatic run_model(input int ncyc, input int drop_t, input string tag);
        int            last_issue, e_addr, e_wb, e_rb, e_bank;
        logic          e_w, e_r, e_ps, e_sv;
        logic [DW-1:0] e_wd, e_sd;
        last_issue = (drop_t > 0) ? drop_t + (PKT_LEN - 1) - ((drop_t - 1) % PKT_LEN) : 32'h3fff_0000;
        enable = 1'b1;
        for (int t = 1; t <= ncyc; t++) begin
            @(negedge clk);
            e_addr = (t <= last_issue) ? (t - 1) % DEPTH : last_issue % DEPTH;
            e_w    = (t >= 2) && (t <= last_issue + 1);
            e_wb   = e_w ? ((t - 2) / PKT_LEN) % 2 : 0;
            e_wd   = e_w ? mem[(t - 2) % DEPTH] : '0;
            e_r    = (t >= PKT_LEN + 1) && (t <= last_issue + PKT_LEN);
            e_rb   = e_r ? ((t - PKT_LEN - 1) / PKT_LEN) % 2 : 0;
            e_ps   = e_r && (((t - PKT_LEN - 1) % PKT_LEN) == 0);
            e_sv   = (t >= PKT_LEN + 2) && (t <= last_issue + PKT_LEN + 1);
            e_sd   = e_sv ? mem[(t - PKT_LEN - 2) % DEPTH] : '0;
            e_bank = (t <= last_issue) ? ((t - 1) / PKT_LEN) % 2 : (last_issue / PKT_LEN) % 2;

            checks++;
            if (bram_addr !== AW'(e_addr)) begin
                errors++; $display("[TB] FAIL %s addr t=%0d got %0d exp %0d", tag, t, bram_addr, e_addr);
            end
            checks++;
            if ({wr_en_1, wr_en_0} !== {e_w && (e_wb == 1), e_w && (e_wb == 0)}) begin
                errors++; $display("[TB] FAIL %s wr_en t=%0d got %b%b exp w=%0d bank=%0d", tag, t, wr_en_1, wr_en_0, e_w, e_wb);
            end
            checks++;
            if (din_0 !== ((e_w && e_wb == 0) ? e_wd : '0) || din_1 !== ((e_w && e_wb == 1) ? e_wd : '0)) begin
                errors++; $display("[TB] FAIL %s din t=%0d got %h/%h exp word %h bank %0d", tag, t, din_0, din_1, e_wd, e_wb);
            end
            checks++;
            if ({rd_en_1, rd_en_0} !== {e_r && (e_rb == 1), e_r && (e_rb == 0)}) begin
                errors++; $display("[TB] FAIL %s rd_en t=%0d got %b%b exp r=%0d bank=%0d", tag, t, rd_en_1, rd_en_0, e_r, e_rb);
            end
            checks++;
            if (pkt_start !== e_ps) begin
                errors++; $display("[TB] FAIL %s pkt_start t=%0d got %b exp %b", tag, t, pkt_start, e_ps);
            end
            checks++;
            if (sr_valid !== e_sv || sr_out !== e_sd) begin
                errors++; $display("[TB] FAIL %s sr t=%0d got %b/%h exp %b/%h", tag, t, sr_valid, sr_out, e_sv, e_sd);
            end
            if (t <= last_issue + PKT_LEN) begin
                checks++;
                if (bank !== 1'(e_bank)) begin
                    errors++; $display("[TB] FAIL %s bank t=%0d got %b exp %0d", tag, t, bank, e_bank);
                end
            end
            if (t == drop_t) enable = 1'b0;
        end
        if (drop_t > 0) begin
            checks++;
            if (push0 + push1 != last_issue || pop0 + pop1 != last_issue) begin
                errors++; $display("[TB] FAIL %s totals writes %0d reads %0d exp %0d each", tag, push0 + push1, pop0 + pop1, last_issue);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bram_addr, wr_en_0, wr_en_1, din_0, din_1, rd_en_0, rd_en_1, sr_out, sr_valid, bank, pkt_start, ovf, udf} !== '0) begin
            errors++; $display("[TB] FAIL reset_outputs addr=%0d wr=%b%b rd=%b%b sr=%b bank=%b exp all 0",
                               bram_addr, wr_en_1, wr_en_0, rd_en_1, rd_en_0, sr_valid, bank);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bram_addr !== '0 || wr_en_0 !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_release got addr %0d exp 0", bram_addr);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bram_addr !== AW'(1)) begin
            errors++; $display("[TB] FAIL first_advance got addr %0d exp 1", bram_addr);
        end
    endtask

    task automatic test_basic();
        do_reset(1'b1);
        run_model(3 * PKT_LEN + 10, 0, "basic");
    endtask

    task automatic test_wrap();
        do_reset(1'b0);
        run_model(DEPTH + PKT_LEN + 70, 0, "wrap");
    endtask

    task automatic test_drain_run();
        do_reset(1'b0);
        run_model(300, 2 * PKT_LEN + 21, "drain_run");
    endtask

    task automatic test_drain_prime();
        do_reset(1'b0);
        run_model(200, 30, "drain_prime");
    endtask

    task automatic test_overflow();
        do_reset(1'b0);
        enable = 1'b1;
        for (int t = 1; t <= 131; t++) begin
            @(negedge clk);
            if (t == 79) begin
                checks++;
                if (ovf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_pre got %b exp 0", ovf); end
            end
            if (t >= 80 && t <= 82) begin
                full_1 = 1'b1;
                #1;
                checks++;
                if (wr_en_1 !== 1'b0) begin errors++; $display("[TB] FAIL ovf_suppress t=%0d got %b exp 0", t, wr_en_1); end
            end
            if (t == 83) full_1 = 1'b0;
            if (t == 84) begin
                checks++;
                if (ovf !== ERR_EN) begin errors++; $display("[TB] FAIL ovf_flag got %b exp %b", ovf, ERR_EN); end
            end
            if (t == 131) begin
                checks++;
                if (push1 != PKT_LEN - 3) begin errors++; $display("[TB] FAIL ovf_drops got %0d writes exp %0d", push1, PKT_LEN - 3); end
                checks++;
                if (udf !== 1'b0) begin errors++; $display("[TB] FAIL ovf_udf got %b exp 0", udf); end
            end
        end
    endtask

    task automatic test_underflow();
        do_reset(1'b0);
        enable = 1'b1;
        for (int t = 1; t <= 72; t++) begin
            @(negedge clk);
            if (t == 70) begin
                checks++;
                if (sr_valid !== 1'b1 || sr_out !== mem[4] || udf !== 1'b0) begin
                    errors++; $display("[TB] FAIL udf_pre got %b/%h udf %b exp 1/%h udf 0", sr_valid, sr_out, udf, mem[4]);
                end
                empty_0 = 1'b1;
                #1;
                checks++;
                if (rd_en_0 !== 1'b0) begin errors++; $display("[TB] FAIL udf_suppress got %b exp 0", rd_en_0); end
            end
            if (t == 71) begin
                checks++;
                if (sr_valid !== 1'b0 || sr_out !== '0) begin errors++; $display("[TB] FAIL udf_slot got %b/%h exp 0/0", sr_valid, sr_out); end
                checks++;
                if (udf !== ERR_EN) begin errors++; $display("[TB] FAIL udf_flag got %b exp %b", udf, ERR_EN); end
                empty_0 = 1'b0;
            end
            if (t == 72) begin
                checks++;
                if (sr_valid !== 1'b1 || sr_out !== mem[5]) begin
                    errors++; $display("[TB] FAIL udf_resume got %b/%h exp 1/%h", sr_valid, sr_out, mem[5]);
                end
            end
        end
    endtask

    task automatic test_reset_midrun();
        do_reset(1'b0);
        enable = 1'b1;
        for (int t = 1; t <= 2 * PKT_LEN + 31; t++) begin
            @(negedge clk);
        end
        checks++;
        if ((wr_en_0 | wr_en_1) !== 1'b1 || (rd_en_0 | rd_en_1) !== 1'b1) begin
            errors++; $display("[TB] FAIL midrun_active got wr %b%b rd %b%b exp activity", wr_en_1, wr_en_0, rd_en_1, rd_en_0);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bram_addr, wr_en_0, wr_en_1, din_0, din_1, rd_en_0, rd_en_1, sr_out, sr_valid, bank, pkt_start, ovf, udf} !== '0) begin
            errors++; $display("[TB] FAIL midrun_reset addr=%0d wr=%b%b rd=%b%b sr=%b bank=%b exp all 0",
                               bram_addr, wr_en_1, wr_en_0, rd_en_1, rd_en_0, sr_valid, bank);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_model(PKT_LEN + 80, 0, "restart");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_drain_run();
        test_drain_prime();
        test_overflow();
        test_underflow();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
